// File: rtl/work_loader_pkg.sv
// work_loader shared types and constants.
// Define WORK_LOADER_CHECKSUM_EN to add a trailing XOR checksum word per frame.
package work_loader_pkg;

    localparam int DATA_W    = 32;
    localparam int TGT_WORDS = 8;
    localparam int MSG_WORDS = 13;
    localparam int TGT_BITS  = 256;
    localparam int MSG_BITS  = 408;
    localparam int CNT_W     = 4;

    localparam logic [7:0] OPC_TARGET = 8'h01;
    localparam logic [7:0] OPC_MSG    = 8'h02;

`ifdef WORK_LOADER_CHECKSUM_EN
    localparam int CSUM_WORDS = 1;
`else
    localparam int CSUM_WORDS = 0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD_TGT,
        LOAD_MSG,
        DISCARD,
        COMMIT
    } state_t;

    // Index of the final word after the header for the given frame type.
    function automatic logic [CNT_W-1:0] last_index(input logic is_msg);
        if (is_msg) return CNT_W'(MSG_WORDS - 1 + CSUM_WORDS);
        return CNT_W'(TGT_WORDS - 1 + CSUM_WORDS);
    endfunction

endpackage

// File: rtl/work_loader_if.sv
// work_loader input stream: 32-bit words with valid/ready and frame end.
// Optional checksum feature: WORK_LOADER_CHECKSUM_EN (no effect here).
interface work_loader_if;
    import work_loader_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/work_loader_frame_counter.sv
// Payload word counter with terminal-count compare per frame type.
// WORK_LOADER_CHECKSUM_EN extends the terminal count by one word.
module work_loader_frame_counter
    import work_loader_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             is_msg,
    output logic [CNT_W-1:0] cnt,
    output logic             at_term
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear on a new header, advance on each accepted payload word.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign at_term = (cnt_q == last_index(is_msg));

endmodule

// File: rtl/work_loader.sv
// work_loader: assembles target/message frames and commits them atomically.
// Define WORK_LOADER_CHECKSUM_EN to require and verify a trailing XOR word.
module work_loader
    import work_loader_pkg::*;
(
    input  logic                clk,
    input  logic                n_rst,
    work_loader_if.slave        stream,
    input  logic                err_clear,
    output logic [TGT_BITS-1:0] target_out,
    output logic [MSG_BITS-1:0] msg_out,
    output logic                new_target,
    output logic                new_msg,
    output logic                frame_err,
    output logic                busy
);

    state_t state_q, state_d;
    logic   is_msg_q, is_msg_d;

    logic [TGT_BITS-1:0] tgt_sh_q, tgt_sh_d;
    logic [MSG_BITS-1:0] msg_sh_q, msg_sh_d;
    logic [TGT_BITS-1:0] target_q, target_d;
    logic [MSG_BITS-1:0] msg_q, msg_d;
    logic                new_tgt_q, new_tgt_d;
    logic                new_msg_q, new_msg_d;
    logic                err_q, err_d;

    logic             cnt_clr;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt;
    logic             at_term;
    logic             xfer;
    logic             err_ev;
    logic             csum_ok;
    logic [7:0]       opc;

`ifdef WORK_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
    assign csum_ok = (csum_q == stream.in_data);
`else
    assign csum_ok = 1'b1;
`endif

    assign xfer = stream.in_valid & stream.in_ready;
    assign opc  = stream.in_data[31:24];

    work_loader_frame_counter u_cnt (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .is_msg  (is_msg_q),
        .cnt     (cnt),
        .at_term (at_term)
    );

    // Frame FSM: shadow fill, length/checksum judgement and commit.
    always_comb begin
        state_d   = state_q;
        is_msg_d  = is_msg_q;
        tgt_sh_d  = tgt_sh_q;
        msg_sh_d  = msg_sh_q;
        target_d  = target_q;
        msg_d     = msg_q;
        new_tgt_d = 1'b0;
        new_msg_d = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        err_ev    = 1'b0;
`ifdef WORK_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    cnt_clr = 1'b1;
`ifdef WORK_LOADER_CHECKSUM_EN
                    csum_d  = stream.in_data;
`endif
                    if (opc == OPC_TARGET || opc == OPC_MSG) begin
                        is_msg_d = (opc == OPC_MSG);
                        if (stream.in_last) begin
                            err_ev = 1'b1;
                        end else begin
                            state_d = (opc == OPC_MSG) ? LOAD_MSG : LOAD_TGT;
                        end
                    end else begin
                        err_ev = 1'b1;
                        if (!stream.in_last) state_d = DISCARD;
                    end
                end
            end
            LOAD_TGT, LOAD_MSG: begin
                if (xfer) begin
`ifdef WORK_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ stream.in_data;
`endif
                    if (state_q == LOAD_TGT) begin
                        for (int k = 0; k < TGT_WORDS; k++) begin
                            if (cnt == CNT_W'(k))
                                tgt_sh_d[TGT_BITS-1-32*k -: 32] = stream.in_data;
                        end
                    end else begin
                        for (int k = 0; k < MSG_WORDS - 1; k++) begin
                            if (cnt == CNT_W'(k))
                                msg_sh_d[MSG_BITS-1-32*k -: 32] = stream.in_data;
                        end
                        if (cnt == CNT_W'(MSG_WORDS - 1))
                            msg_sh_d[23:0] = stream.in_data[31:8];
                    end
                    if (stream.in_last) begin
                        if (at_term && csum_ok) begin
                            state_d = COMMIT;
                        end else begin
                            err_ev  = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (at_term) begin
                        err_ev  = 1'b1;
                        state_d = DISCARD;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (xfer && stream.in_last) state_d = IDLE;
            end
            COMMIT: begin
                if (is_msg_q) begin
                    msg_d     = msg_sh_q;
                    new_msg_d = 1'b1;
                end else begin
                    target_d  = tgt_sh_q;
                    new_tgt_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (err_ev) begin
            err_d = 1'b1;
        end else if (err_clear) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State, shadow and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            is_msg_q  <= 1'b0;
            tgt_sh_q  <= '0;
            msg_sh_q  <= '0;
            target_q  <= '0;
            msg_q     <= '0;
            new_tgt_q <= 1'b0;
            new_msg_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_msg_q  <= is_msg_d;
            tgt_sh_q  <= tgt_sh_d;
            msg_sh_q  <= msg_sh_d;
            target_q  <= target_d;
            msg_q     <= msg_d;
            new_tgt_q <= new_tgt_d;
            new_msg_q <= new_msg_d;
            err_q     <= err_d;
        end
    end

`ifdef WORK_LOADER_CHECKSUM_EN
    // Running XOR of header and payload words.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign stream.in_ready = (state_q != COMMIT);
    assign target_out      = target_q;
    assign msg_out         = msg_q;
    assign new_target      = new_tgt_q;
    assign new_msg         = new_msg_q;
    assign frame_err       = err_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_work_loader.sv
// Testbench for work_loader: directed and randomized frames against
// a frame-level reference model.
module tb_work_loader;

    typedef logic [31:0] wq_t[$];

`ifdef WORK_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         err_clear = 1'b0;
    logic [255:0] target_out;
    logic [407:0] msg_out;
    logic         new_target;
    logic         new_msg;
    logic         frame_err;
    logic         busy;

    work_loader_if bus ();

    work_loader dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .stream     (bus),
        .err_clear  (err_clear),
        .target_out (target_out),
        .msg_out    (msg_out),
        .new_target (new_target),
        .new_msg    (new_msg),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int nt = 0;
    int nm = 0;
    int rlow = 0;
    int both = 0;
    int consec = 0;
    logic prev_s = 1'b0;

    logic [255:0] e_tgt = '0;
    logic [407:0] e_msg = '0;
    logic         e_err = 1'b0;

    always @(negedge clk) begin
        if (new_target) nt++;
        if (new_msg) nm++;
        if (!bus.in_ready) rlow++;
        if (new_target && new_msg) both++;
        if (prev_s && (new_target || new_msg)) consec++;
        prev_s = new_target | new_msg;
    end

    function automatic wq_t add_csum(input wq_t f);
`ifdef WORK_LOADER_CHECKSUM_EN
        logic [31:0] x = '0;
        foreach (f[i]) x ^= f[i];
        f.push_back(x);
`endif
        return f;
    endfunction

    function automatic wq_t rand_frame(input logic [7:0] opc, input int n);
        wq_t f;
        f.push_back({opc, 24'($urandom)});
        for (int i = 0; i < n; i++) f.push_back($urandom);
        return add_csum(f);
    endfunction

    // 0 = malformed, 1 = target, 2 = message
    function automatic int kind_of(input wq_t f);
        logic [7:0] opc;
        int n;
        opc = f[0][31:24];
        n = (opc == 8'h01) ? 8 : (opc == 8'h02) ? 13 : 0;
        if (n == 0) return 0;
        if (f.size() != 1 + n + CS) return 0;
`ifdef WORK_LOADER_CHECKSUM_EN
        begin
            logic [31:0] x = '0;
            for (int i = 0; i < f.size() - 1; i++) x ^= f[i];
            if (x != f[f.size()-1]) return 0;
        end
`endif
        return (opc == 8'h01) ? 1 : 2;
    endfunction

    task automatic apply_model(input wq_t f);
        case (kind_of(f))
            1: begin
                e_tgt = '0;
                for (int i = 1; i <= 8; i++) e_tgt = {e_tgt[223:0], f[i]};
            end
            2: begin
                e_msg = '0;
                for (int i = 1; i <= 12; i++) e_msg = {e_msg[375:0], f[i]};
                e_msg = {e_msg[383:0], f[13][31:8]};
            end
            default: e_err = 1'b1;
        endcase
    endtask

    task automatic clr_cnt();
        nt = 0;
        nm = 0;
        rlow = 0;
    endtask

    // Drives f word by word from a negedge; returns at the negedge
    // following the transfer of the final word.
    task automatic send(input wq_t f, input int stall, input bit with_last);
        for (int i = 0; i < f.size(); i++) begin
            while ($urandom_range(99) < stall) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = f[i];
            bus.in_last  = with_last && (i == f.size() - 1);
            begin
                int t = 0;
                while (!bus.in_ready && t < 8) begin
                    @(negedge clk);
                    t++;
                end
                if (!bus.in_ready) begin
                    failures++;
                    $display("FAIL ready_timeout: in_ready=%b want 1", bus.in_ready);
                end
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.in_data = '0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (target_out !== 256'h0 || msg_out !== 408'h0) begin
            failures++;
            $display("FAIL reset_data: tgt=%h msg=%h want 0", target_out, msg_out);
        end
        checks++;
        if ({new_target, new_msg, frame_err, busy, bus.in_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_ctrl: nt/nm/err/busy/rdy=%b want 00001",
                     {new_target, new_msg, frame_err, busy, bus.in_ready});
        end
    endtask

    task automatic test_target();
        wq_t f;
        f.push_back(32'h01000000);
        f.push_back(32'h00000000);
        f.push_back(32'h0000FFFF);
        for (int i = 0; i < 6; i++) f.push_back(32'hFFFFFFFF);
        f = add_csum(f);
        apply_model(f);
        send(f, 0, 1);
        checks++;
        if ({bus.in_ready, new_target, busy} !== 3'b001) begin
            failures++;
            $display("FAIL tgt_commit_cycle: rdy/nt/busy=%b want 001",
                     {bus.in_ready, new_target, busy});
        end
        @(negedge clk);
        checks++;
        if ({new_target, new_msg} !== 2'b10) begin
            failures++;
            $display("FAIL tgt_strobe: nt/nm=%b want 10", {new_target, new_msg});
        end
        checks++;
        if (target_out !== 256'h00000000_0000FFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF
            || target_out !== e_tgt) begin
            failures++;
            $display("FAIL tgt_value: got %h want %h", target_out, e_tgt);
        end
        checks++;
        if (msg_out !== 408'h0) begin
            failures++;
            $display("FAIL tgt_msg_untouched: got %h want 0", msg_out);
        end
        @(negedge clk);
        checks++;
        if (new_target !== 1'b0) begin
            failures++;
            $display("FAIL tgt_strobe_len: nt=%b want 0", new_target);
        end
    endtask

    task automatic test_message();
        wq_t f;
        f.push_back(32'h02000000);
        for (int k = 0; k < 12; k++) f.push_back(32'(32'h11111111 * (k + 1)));
        f.push_back(32'hDDDDDDAA);
        f = add_csum(f);
        apply_model(f);
        send(f, 0, 1);
        @(negedge clk);
        checks++;
        if ({new_target, new_msg} !== 2'b01) begin
            failures++;
            $display("FAIL msg_strobe: nt/nm=%b want 01", {new_target, new_msg});
        end
        checks++;
        if (msg_out[23:0] !== 24'hDDDDDD || msg_out[407:376] !== 32'h11111111) begin
            failures++;
            $display("FAIL msg_ends: lo=%h hi=%h want dddddd 11111111",
                     msg_out[23:0], msg_out[407:376]);
        end
        checks++;
        if (msg_out !== e_msg || target_out !== e_tgt) begin
            failures++;
            $display("FAIL msg_value: msg=%h want %h", msg_out, e_msg);
        end
        @(negedge clk);
        checks++;
        if (new_msg !== 1'b0) begin
            failures++;
            $display("FAIL msg_strobe_len: nm=%b want 0", new_msg);
        end
    endtask

    task automatic test_short();
        wq_t f;
        f = rand_frame(8'h01, 0);
        f = '{f[0]};
        for (int i = 0; i < 3; i++) f.push_back($urandom);
        clr_cnt();
        apply_model(f);
        send(f, 0, 1);
        settle();
        checks++;
        if (frame_err !== 1'b1 || nt != 0 || target_out !== e_tgt) begin
            failures++;
            $display("FAIL short_frame: err=%b nt=%0d tgt=%h want 1 0 %h",
                     frame_err, nt, target_out, e_tgt);
        end
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        e_err = 1'b0;
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear: err=%b want 0", frame_err);
        end
    endtask

    task automatic test_bad_opcode();
        wq_t f;
        f.push_back(32'h07000000);
        for (int i = 0; i < 4; i++) f.push_back($urandom);
        clr_cnt();
        apply_model(f);
        send(f, 0, 1);
        settle();
        checks++;
        if (frame_err !== 1'b1 || busy !== 1'b0 || rlow != 0) begin
            failures++;
            $display("FAIL bad_opcode: err=%b busy=%b rlow=%0d want 1 0 0",
                     frame_err, busy, rlow);
        end
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        e_err = 1'b0;
        f = rand_frame(8'h01, 8);
        clr_cnt();
        apply_model(f);
        send(f, 0, 1);
        settle();
        checks++;
        if (nt != 1 || target_out !== e_tgt || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL after_discard: nt=%0d tgt=%h want 1 %h", nt, target_out, e_tgt);
        end
    endtask

    task automatic test_long();
        wq_t f;
        f = rand_frame(8'h01, 9);
        clr_cnt();
        apply_model(f);
        send(f, 0, 1);
        settle();
        checks++;
        if (frame_err !== 1'b1 || nt != 0 || busy !== 1'b0 || target_out !== e_tgt) begin
            failures++;
            $display("FAIL long_frame: err=%b nt=%0d busy=%b want 1 0 0",
                     frame_err, nt, busy);
        end
        f = rand_frame(8'h02, 13);
        clr_cnt();
        apply_model(f);
        send(f, 0, 1);
        settle();
        checks++;
        if (nm != 1 || msg_out !== e_msg) begin
            failures++;
            $display("FAIL after_long: nm=%0d msg=%h want 1 %h", nm, msg_out, e_msg);
        end
    endtask

    task automatic test_stall();
        wq_t f;
        wq_t g;
        logic [407:0] ref_m;
        f = rand_frame(8'h02, 13);
        g = rand_frame(8'h02, 13);
        send(f, 0, 1);
        settle();
        ref_m = msg_out;
        send(g, 0, 1);
        settle();
        clr_cnt();
        apply_model(f);
        send(f, 50, 1);
        settle();
        checks++;
        if (msg_out !== ref_m || msg_out !== e_msg) begin
            failures++;
            $display("FAIL stall_value: got %h want %h", msg_out, e_msg);
        end
        checks++;
        if (rlow != 1 || nm != 1) begin
            failures++;
            $display("FAIL stall_ready: rlow=%0d nm=%0d want 1 1", rlow, nm);
        end
    endtask

    task automatic test_err_priority();
        wq_t f;
        f.push_back(32'h02000000);
        err_clear = 1'b1;
        apply_model(f);
        send(f, 0, 1);
        err_clear = 1'b0;
        checks++;
        if (frame_err !== 1'b1) begin
            failures++;
            $display("FAIL set_wins: err=%b want 1", frame_err);
        end
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        e_err = 1'b0;
    endtask

    task automatic test_reset_mid();
        wq_t f;
        wq_t p;
        f = rand_frame(8'h02, 13);
        for (int i = 0; i < 6; i++) p.push_back(f[i]);
        send(p, 0, 0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy: busy=%b want 1", busy);
        end
        n_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (target_out !== 256'h0 || msg_out !== 408'h0 ||
            {new_target, new_msg, frame_err, busy, bus.in_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL mid_reset: tgt=%h msg=%h ctrl=%b want 0 0 00001", target_out,
                     msg_out, {new_target, new_msg, frame_err, busy, bus.in_ready});
        end
        n_rst = 1'b1;
        e_tgt = '0;
        e_msg = '0;
        e_err = 1'b0;
        f = rand_frame(8'h02, 13);
        clr_cnt();
        apply_model(f);
        send(f, 0, 1);
        settle();
        checks++;
        if (nm != 1 || msg_out !== e_msg || target_out !== 256'h0) begin
            failures++;
            $display("FAIL post_reset: nm=%0d msg=%h want 1 %h", nm, msg_out, e_msg);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            wq_t f;
            int sel;
            int k;
            logic [7:0] opc;
            sel = $urandom_range(5);
            opc = $urandom_range(1) ? 8'h01 : 8'h02;
            case (sel)
                0: f = rand_frame(8'h01, 8);
                1: f = rand_frame(8'h02, 13);
                2: f = rand_frame(opc, $urandom_range((opc == 8'h01) ? 7 : 12));
                3: f = rand_frame(opc, ((opc == 8'h01) ? 9 : 14) + $urandom_range(2));
                4: begin
                    opc = 8'($urandom);
                    if (opc == 8'h01 || opc == 8'h02) opc = 8'h55;
                    f = rand_frame(opc, $urandom_range(5));
                end
                default: f = rand_frame(opc, 0);
            endcase
            if ($urandom_range(3) == 0) begin
                err_clear = 1'b1;
                @(negedge clk);
                err_clear = 1'b0;
                e_err = 1'b0;
            end
            k = kind_of(f);
            clr_cnt();
            apply_model(f);
            send(f, $urandom_range(40), 1);
            settle();
            checks++;
            if (target_out !== e_tgt || msg_out !== e_msg) begin
                failures++;
                $display("FAIL rnd_data it=%0d: tgt=%h msg=%h want %h %h",
                         it, target_out, msg_out, e_tgt, e_msg);
            end
            checks++;
            if (frame_err !== e_err) begin
                failures++;
                $display("FAIL rnd_err it=%0d: err=%b want %b", it, frame_err, e_err);
            end
            checks++;
            if (nt != int'(k == 1) || nm != int'(k == 2) || rlow != int'(k != 0)) begin
                failures++;
                $display("FAIL rnd_strobe it=%0d: nt=%0d nm=%0d rlow=%0d kind=%0d",
                         it, nt, nm, rlow, k);
            end
        end
        checks++;
        if (both != 0 || consec != 0) begin
            failures++;
            $display("FAIL strobe_rules: both=%0d consec=%0d want 0 0", both, consec);
        end
    endtask

    initial begin
        test_reset();
        test_target();
        test_message();
        test_short();
        test_bad_opcode();
        test_long();
        test_stall();
        test_err_priority();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
